// File: rtl/hilo_pkg.sv
// Shared encodings and defaults for the HI/LO sequencer.
package hilo_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 40;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MSTART = 3'd1,
    S_MWAIT  = 3'd2,
    S_DSTART = 3'd3,
    S_DWAIT  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic is_start_state(input state_e s);
    return (s == S_MSTART) || (s == S_DSTART);
  endfunction

  function automatic logic is_wait_state(input state_e s);
    return (s == S_MWAIT) || (s == S_DWAIT);
  endfunction

endpackage

// File: rtl/hilo_wdog.sv
// Wait-state cycle counter; expired_c marks the last permitted WAIT cycle.
module hilo_wdog
  import hilo_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // The increment taken on this cycle brings the count to TIMEOUT.
  assign expired_c = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO sequencer: launches the multiplier/divider, captures results,
// and reports stall, completion, divide-by-zero and watchdog status.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             OpStart,
  input  logic [1:0]       OpSel,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Timeout,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] OperA,
  output logic [WIDTH-1:0] OperB,
  output logic             MultStart,
  input  logic             MultStop,
  input  logic [WIDTH-1:0] MultHI,
  input  logic [WIDTH-1:0] MultLO,
  output logic             DivStart,
  input  logic             DivStop,
  input  logic             DivZeroIn,
  input  logic [WIDTH-1:0] DivHI,
  input  logic [WIDTH-1:0] DivLO
);

  state_e state;
  logic   expired_c;

  hilo_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .Clock     (Clock),
    .Reset     (Reset),
    .clear     (is_start_state(state)),
    .enable    (is_wait_state(state)),
    .expired_c (expired_c)
  );

  // Outputs are registered alongside the state, so each is set on the
  // transition into the state in which it must be visible.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      Timeout   <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      OperA     <= '0;
      OperB     <= '0;
      MultStart <= 1'b0;
      DivStart  <= 1'b0;
    end else begin
      MultStart <= 1'b0;
      DivStart  <= 1'b0;
      Done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (OpStart) begin
            OperA   <= SrcA;
            OperB   <= SrcB;
            DivZero <= 1'b0;
            Timeout <= 1'b0;
            unique case (op_e'(OpSel))
              OP_MULT: begin
                state     <= S_MSTART;
                MultStart <= 1'b1;
                Busy      <= 1'b1;
              end
              OP_DIV: begin
                if (SrcB == '0) begin
                  DivZero <= 1'b1;
                  state   <= S_DONE;
                  Done    <= 1'b1;
                end else begin
                  state    <= S_DSTART;
                  DivStart <= 1'b1;
                  Busy     <= 1'b1;
                end
              end
              OP_MTHI: begin
                HI    <= SrcA;
                state <= S_DONE;
                Done  <= 1'b1;
              end
              OP_MTLO: begin
                LO    <= SrcA;
                state <= S_DONE;
                Done  <= 1'b1;
              end
            endcase
          end
        end
        // Stop seen while the start pulse is out belongs to an older request.
        S_MSTART: state <= S_MWAIT;
        S_DSTART: state <= S_DWAIT;
        S_MWAIT: begin
          if (MultStop) begin
            HI    <= MultHI;
            LO    <= MultLO;
            state <= S_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else if (expired_c) begin
            Timeout <= 1'b1;
            state   <= S_DONE;
            Done    <= 1'b1;
            Busy    <= 1'b0;
          end
        end
        S_DWAIT: begin
          if (DivStop) begin
            if (DivZeroIn) begin
              DivZero <= 1'b1;
            end else begin
              HI <= DivHI;
              LO <= DivLO;
            end
            state <= S_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else if (expired_c) begin
            Timeout <= 1'b1;
            state   <= S_DONE;
            Done    <= 1'b1;
            Busy    <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus queues expected Done results,
// a negedge monitor pops and compares them.
module tb_hilo_unit;

  localparam logic [1:0] MULT = 2'b00;
  localparam logic [1:0] DIV  = 2'b01;
  localparam logic [1:0] MTHI = 2'b10;
  localparam logic [1:0] MTLO = 2'b11;
  localparam int TO = 40;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        OpStart = 1'b0;
  logic [1:0]  OpSel = 2'b00;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        Busy, Done, DivZero, Timeout;
  logic [31:0] HI, LO, OperA, OperB;
  logic        MultStart, DivStart;
  logic        MultStop = 1'b0, DivStop = 1'b0, DivZeroIn = 1'b0;
  logic [31:0] MultHI = '0, MultLO = '0, DivHI = '0, DivLO = '0;

  hilo_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .OpStart(OpStart), .OpSel(OpSel),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Timeout(Timeout), .HI(HI), .LO(LO),
    .OperA(OperA), .OperB(OperB), .MultStart(MultStart),
    .MultStop(MultStop), .MultHI(MultHI), .MultLO(MultLO),
    .DivStart(DivStart), .DivStop(DivStop), .DivZeroIn(DivZeroIn),
    .DivHI(DivHI), .DivLO(DivLO)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          cyc;
    logic [31:0] hi, lo, a, b;
    logic        dz, to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   busy_cnt = 0, mult_pulses = 0, div_pulses = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: counts pulses/busy cycles and scores every Done pulse.
  always @(negedge Clock) begin
    if (Busy) busy_cnt++;
    if (MultStart) mult_pulses++;
    if (DivStart) div_pulses++;
    if (Done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 64'(mon_e.cyc), 64'(cyc));
        chk("hi", 64'(HI), 64'(mon_e.hi));
        chk("lo", 64'(LO), 64'(mon_e.lo));
        chk("oper_a", 64'(OperA), 64'(mon_e.a));
        chk("oper_b", 64'(OperB), 64'(mon_e.b));
        chk("divzero", 64'(DivZero), 64'(mon_e.dz));
        chk("timeout", 64'(Timeout), 64'(mon_e.to));
        chk("busy_at_done", 64'(Busy), 64'd0);
      end
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // n_stop: wait cycle (1-based) in which Stop is driven; <=0 means never.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n_stop, input logic dz_in, input logic stray,
                        input logic reissue);
    exp_t e;
    logic signed [63:0] prod;
    logic is_wait, has_stop;
    int   last, c0, mp0, dp0, b0;
    prod     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    is_wait  = (op == MULT) || (op == DIV && b != 0);
    has_stop = (n_stop > 0) && (n_stop <= TO);
    last     = has_stop ? n_stop : TO;
    mp0 = mult_pulses; dp0 = div_pulses; b0 = busy_cnt;
    OpSel = op; SrcA = a; SrcB = b; OpStart = 1'b1;
    tick;
    OpStart = 1'b0;
    c0 = cyc;
    e.a = a; e.b = b; e.dz = 1'b0; e.to = 1'b0;
    if (!is_wait) begin
      e.cyc = c0;
      if (op == MTHI) m_hi = a;
      if (op == MTLO) m_lo = a;
      if (op == DIV) e.dz = 1'b1;
    end else begin
      e.cyc = c0 + last + 1;
      if (!has_stop) e.to = 1'b1;
      else if (op == MULT) {m_hi, m_lo} = prod;
      else if (dz_in) e.dz = 1'b1;
      else begin m_hi = a % b; m_lo = a / b; end
    end
    e.hi = m_hi; e.lo = m_lo;
    exp_q.push_back(e);
    if (is_wait) begin
      if (stray) begin
        MultStop = 1'b1; MultHI = 32'hBAD0BAD0; MultLO = 32'hBAD1BAD1;
      end
      for (int k = 1; k <= last; k++) begin
        tick;
        MultStop = 1'b0;
        OpStart = reissue && (k < 4);
        if (reissue) begin SrcA = 32'h55 + 32'(k); SrcB = 32'h66; OpSel = DIV; end
        if (k == last && has_stop) begin
          if (op == MULT) begin MultStop = 1'b1; {MultHI, MultLO} = prod; end
          else begin DivStop = 1'b1; DivZeroIn = dz_in; DivHI = a % b; DivLO = a / b; end
        end
      end
      OpStart = 1'b0;
      tick;
      MultStop = 1'b0; DivStop = 1'b0; DivZeroIn = 1'b0;
    end
    tick;
    chk("mult_start_pulses", 64'(mult_pulses - mp0), 64'(is_wait && op == MULT));
    chk("div_start_pulses", 64'(div_pulses - dp0), 64'(is_wait && op == DIV));
    chk("busy_cycles", 64'(busy_cnt - b0), 64'(is_wait ? last + 1 : 0));
  endtask

  initial begin
    int mp0;
    repeat (3) tick;
    Reset = 1'b0;
    tick;
    chk("reset_hi_lo", {HI, LO}, 64'd0);
    chk("reset_oper", {OperA, OperB}, 64'd0);
    chk("reset_flags", 64'({Busy, Done, DivZero, Timeout, MultStart, DivStart}), 64'd0);

    run_op(MULT, 32'd7, 32'hFFFF_FFFD, 32, 1'b0, 1'b1, 1'b1);
    run_op(DIV, 32'd100, 32'd7, 32, 1'b0, 1'b0, 1'b0);
    run_op(DIV, 32'd5, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    chk("divzero_sticky", 64'(DivZero), 64'd1);
    run_op(DIV, 32'd9, 32'd3, 3, 1'b1, 1'b0, 1'b0);
    run_op(MTHI, 32'hDEAD_BEEF, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    chk("divzero_cleared", 64'(DivZero), 64'd0);
    run_op(MTLO, 32'h1234_5678, 32'd1, 0, 1'b0, 1'b0, 1'b0);
    run_op(MULT, 32'h0001_0000, 32'h0001_0000, TO, 1'b0, 1'b0, 1'b0);
    run_op(MULT, 32'd3, 32'd4, 0, 1'b0, 1'b0, 1'b0);
    chk("timeout_sticky", 64'(Timeout), 64'd1);
    run_op(MTLO, 32'h0000_00A5, 32'd2, 0, 1'b0, 1'b0, 1'b0);
    chk("timeout_cleared", 64'(Timeout), 64'd0);

    // Reset during MWAIT, then a late Stop that must be ignored.
    OpSel = MULT; SrcA = 32'd11; SrcB = 32'd13; OpStart = 1'b1;
    tick;
    OpStart = 1'b0;
    repeat (3) tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    mp0 = mult_pulses;
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    MultStop = 1'b1; MultHI = 32'h1111_1111; MultLO = 32'h2222_2222;
    tick;
    MultStop = 1'b0;
    repeat (4) tick;
    chk("rst_mid_hi_lo", {HI, LO}, 64'd0);
    chk("rst_mid_oper", {OperA, OperB}, 64'd0);
    chk("rst_mid_no_start", 64'(mult_pulses - mp0), 64'd0);
    chk("rst_mid_idle", 64'({Busy, Done, DivZero, Timeout}), 64'd0);

    chk("pending_done", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
